// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate array self-check stage: FSM states,
// the stimulus vector table and the bit positions of the gate outputs.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } chkState_e;

    // Stimulus order as (a,b): 00, 10, 01, 11
    localparam logic [0:3] VEC_A = 4'b0101;
    localparam logic [0:3] VEC_B = 4'b0011;

    localparam logic [1:0] LAST_VEC = 2'd3;

    // Position of each gate output inside the 7-bit gate bus
    localparam int P_BIT = 6;
    localparam int Q_BIT = 5;
    localparam int R_BIT = 4;
    localparam int S_BIT = 3;
    localparam int T_BIT = 2;
    localparam int U_BIT = 1;
    localparam int V_BIT = 0;

endpackage

// File: rtl/gate_golden_model.sv
// Combinational golden truth table of the two-input gate array.
module gate_golden_model
    import gate_chk_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    output logic [6:0] expected_o
);

    // Expected value of every gate output for the applied a/b pair
    always_comb begin
        expected_o        = '0;
        expected_o[P_BIT] = a_i & b_i;
        expected_o[Q_BIT] = a_i | b_i;
        expected_o[R_BIT] = ~(a_i & b_i);
        expected_o[S_BIT] = ~(a_i | b_i);
        expected_o[T_BIT] = a_i ^ b_i;
        expected_o[U_BIT] = ~(a_i ^ b_i);
        expected_o[V_BIT] = ~a_i;
    end

endmodule

// File: rtl/gate_vector_checker.sv
// Stimulus/response checker for the gate array: walks the four a/b vectors,
// holds each for SETTLE_CYCLES clocks, samples the gate outputs and
// accumulates a per-vector fail mask, a mismatched-bit count and a pass flag.
module gate_vector_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic [6:0] gate_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [4:0] mismatch_bits,
    output logic [1:0] vec_idx
);

    // The settle counter counts down to zero, so it is loaded with one less
    // than the hold time; this makes SETTLE last exactly SETTLE_CYCLES clocks.
    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

    chkState_e  state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] vecIdx_q, vecIdx_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] failMask_q, failMask_d;
    logic [4:0] mismatch_q, mismatch_d;

    logic [6:0] expected;
    logic [6:0] diff;
    logic [2:0] popCount;
    logic [1:0] nextIdx;

    gate_golden_model u_golden (
        .a_i        (a_q),
        .b_i        (b_q),
        .expected_o (expected)
    );

    // Next-state logic: run sequencing, stimulus selection and result accumulation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        vecIdx_d   = vecIdx_q;
        a_d        = a_q;
        b_d        = b_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        failMask_d = failMask_q;
        mismatch_d = mismatch_q;
        nextIdx    = vecIdx_q + 2'd1;

        diff     = gate_in ^ expected;
        popCount = '0;
        for (int i = 0; i < 7; i++) begin
            popCount = popCount + {2'b00, diff[i]};
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = SETTLE;
                    vecIdx_d   = 2'd0;
                    a_d        = VEC_A[0];
                    b_d        = VEC_B[0];
                    cnt_d      = RELOAD;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    failMask_d = '0;
                    mismatch_d = '0;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SAMPLE: begin
                mismatch_d           = mismatch_q + {2'b00, popCount};
                failMask_d[vecIdx_q] = failMask_q[vecIdx_q] | (diff != '0);
                if (vecIdx_q != LAST_VEC) begin
                    vecIdx_d = nextIdx;
                    a_d      = VEC_A[nextIdx];
                    b_d      = VEC_B[nextIdx];
                    cnt_d    = RELOAD;
                    state_d  = SETTLE;
                end else begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (mismatch_d == '0) && (failMask_d == '0);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers, all cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            vecIdx_q   <= '0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            failMask_q <= '0;
            mismatch_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vecIdx_q   <= vecIdx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            failMask_q <= failMask_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign a             = a_q;
    assign b             = b_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign fail_mask     = failMask_q;
    assign mismatch_bits = mismatch_q;
    assign vec_idx       = vecIdx_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Self-checking bench for gate_vector_checker: emulates a gate array with
// selectable faults and checks run timing, stimulus order and results.
module tb_gate_vector_checker;

    localparam int SETTLE   = 4;
    localparam int RUN_BUSY = 4 * (SETTLE + 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       a;
    logic       b;
    logic [6:0] gate_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;
    logic [4:0] mismatch_bits;
    logic [1:0] vec_idx;

    int         faultMode = 0;
    logic [6:0] randMask [4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         mode;
        logic [3:0] expFail;
        int         expMis;
        logic       expPass;
    } vecRec_t;

    vecRec_t vecTable [4];

    always #5 clk = ~clk;

    gate_vector_checker #(
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .a             (a),
        .b             (b),
        .gate_in       (gate_in),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .fail_mask     (fail_mask),
        .mismatch_bits (mismatch_bits),
        .vec_idx       (vec_idx)
    );

    // Gate array truth values derived from counting how many inputs are high
    function automatic logic [6:0] refGates(input logic ai, input logic bi);
        int ones;
        logic p, q, r, s, t, u, v;
        ones = int'(ai) + int'(bi);
        p = (ones == 2);
        q = (ones >= 1);
        r = !p;
        s = !q;
        t = (ones == 1);
        u = !t;
        v = (ai == 1'b0);
        return {p, q, r, s, t, u, v};
    endfunction

    // Emulated gate array, possibly broken in one of several ways
    function automatic logic [6:0] faultyGates(input int mode, input logic ai, input logic bi,
                                               input logic [6:0] mask);
        logic [6:0] g;
        g = refGates(ai, bi);
        case (mode)
            1:       return g & 7'b1011111;
            2:       return g | 7'b0000001;
            3:       return ~g;
            4:       return g ^ mask;
            default: return g;
        endcase
    endfunction

    // Gate array responds combinationally to the checker's stimulus
    always_comb begin
        gate_in = faultyGates(faultMode, a, b, randMask[{b, a}]);
    end

    // Expected run results: mismatches of the emulated array over all four vectors
    task automatic modelRun(output logic [3:0] f, output int m, output logic p);
        logic [6:0] d;
        logic ai, bi;
        f = '0;
        m = 0;
        for (int i = 0; i < 4; i++) begin
            ai = (i % 2) == 1;
            bi = (i / 2) == 1;
            d = faultyGates(faultMode, ai, bi, randMask[i]) ^ refGates(ai, bi);
            m += $countones(d);
            f[i] = (d != 0);
        end
        p = (m == 0);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Pulse start, then follow the run until done (bounded), collecting timing and a/b order
    task automatic applyStimulus(input string tag, input int extraStartEdge,
                                 output int busyCycles, output int doneEdge,
                                 output logic [7:0] abSeq, output int abCount,
                                 output int idxBad);
        logic [1:0] lastAb;
        busyCycles = 0;
        doneEdge   = 0;
        abSeq      = '0;
        abCount    = 0;
        idxBad     = 0;
        lastAb     = 2'b00;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checkOutput({tag, "_start_busy"}, busy, 1);
        checkOutput({tag, "_start_done"}, done, 0);
        checkOutput({tag, "_start_pass"}, pass, 0);
        checkOutput({tag, "_start_fail_mask"}, fail_mask, 0);
        checkOutput({tag, "_start_mismatch"}, mismatch_bits, 0);
        checkOutput({tag, "_start_vec_idx"}, vec_idx, 0);
        for (int edgeNum = 1; edgeNum <= 200; edgeNum++) begin
            if (done) begin
                doneEdge = edgeNum;
                break;
            end
            if (busy) busyCycles++;
            if (vec_idx !== {b, a}) idxBad++;
            if (abCount == 0 || {a, b} != lastAb) begin
                abSeq  = {abSeq[5:0], a, b};
                abCount++;
                lastAb = {a, b};
            end
            if (edgeNum + 1 == extraStartEdge) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
    endtask

    task automatic runAndCheck(input string tag, input int extraStartEdge,
                               input logic [3:0] expFail, input int expMis, input logic expPass);
        int busyCycles, doneEdge, abCount, idxBad;
        logic [7:0] abSeq;
        applyStimulus(tag, extraStartEdge, busyCycles, doneEdge, abSeq, abCount, idxBad);
        checkOutput({tag, "_busy_cycles"}, busyCycles, RUN_BUSY);
        checkOutput({tag, "_done_edge"}, doneEdge, RUN_BUSY + 1);
        checkOutput({tag, "_ab_count"}, abCount, 4);
        checkOutput({tag, "_ab_order"}, abSeq, 8'b00_10_01_11);
        checkOutput({tag, "_vec_idx_track"}, idxBad, 0);
        checkOutput({tag, "_fail_mask"}, fail_mask, expFail);
        checkOutput({tag, "_mismatch"}, mismatch_bits, expMis);
        checkOutput({tag, "_pass"}, pass, expPass);
        checkOutput({tag, "_busy_after"}, busy, 0);
        checkOutput({tag, "_ab_hold"}, {a, b}, 2'b11);
    endtask

    // Watchdog so the bench always terminates
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] mFail;
        int         mMis;
        logic       mPass;
        logic       reached;

        for (int i = 0; i < 4; i++) randMask[i] = '0;

        vecTable[0] = '{mode: 0, expFail: 4'b0000, expMis: 0,  expPass: 1'b1};
        vecTable[1] = '{mode: 1, expFail: 4'b1110, expMis: 3,  expPass: 1'b0};
        vecTable[2] = '{mode: 2, expFail: 4'b1010, expMis: 2,  expPass: 1'b0};
        vecTable[3] = '{mode: 3, expFail: 4'b1111, expMis: 28, expPass: 1'b0};

        // Reset values while rst_n is held low
        #12;
        checkOutput("rst_a", a, 0);
        checkOutput("rst_b", b, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_pass", pass, 0);
        checkOutput("rst_fail_mask", fail_mask, 0);
        checkOutput("rst_mismatch", mismatch_bits, 0);
        checkOutput("rst_vec_idx", vec_idx, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_done", done, 0);

        // Fixed fault scenarios from the vector table
        for (int i = 0; i < 4; i++) begin
            faultMode = vecTable[i].mode;
            runAndCheck($sformatf("table%0d", i), 0, vecTable[i].expFail,
                        vecTable[i].expMis, vecTable[i].expPass);
        end

        // start during a run is ignored; start in DONE clears results and reruns
        faultMode = 3;
        runAndCheck("ignore_start", 7, 4'b1111, 28, 1'b0);
        faultMode = 0;
        runAndCheck("rerun_from_done", 0, 4'b0000, 0, 1'b1);

        // Reset in the middle of vector 2's settle window
        faultMode = 3;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (vec_idx == 2'd2) begin
                reached = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("midrun_reached_idx2", reached, 1);
        checkOutput("midrun_partial_mismatch", mismatch_bits, 14);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midrun_rst_a", a, 0);
        checkOutput("midrun_rst_b", b, 0);
        checkOutput("midrun_rst_busy", busy, 0);
        checkOutput("midrun_rst_done", done, 0);
        checkOutput("midrun_rst_fail_mask", fail_mask, 0);
        checkOutput("midrun_rst_mismatch", mismatch_bits, 0);
        checkOutput("midrun_rst_vec_idx", vec_idx, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("post_rst_idle_busy", busy, 0);
        checkOutput("post_rst_idle_done", done, 0);
        checkOutput("post_rst_idle_ab", {a, b}, 2'b00);
        checkOutput("post_rst_idle_vec_idx", vec_idx, 0);

        // Randomised per-vector faults against the behavioural model
        faultMode = 4;
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 4; i++) begin
                randMask[i] = ($urandom_range(0, 2) == 0) ? 7'd0 : 7'($urandom);
            end
            modelRun(mFail, mMis, mPass);
            runAndCheck($sformatf("rand%0d", r), 0, mFail, mMis, mPass);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
